// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial sequence detector.
// Watches a valid-qualified 1-bit stream for a PAT_LEN-bit PATTERN (MSB first),
// emits a registered one-cycle match pulse, keeps a saturating match counter
// with a sticky saturation flag, and reports how many history bits are valid.
// OVERLAP selects whether history survives a match.
// Optional feature: define SEQ_DET_MASK_EN to add a live per-bit compare mask
// (pat_mask, 1 = compare, 0 = don't care).
//
// State view (derived from fill, no separate state register):
//   state   | meaning
//   FILLING | fill < PAT_LEN-1, a match cannot be declared on the next valid bit
//   ARMED   | fill >= PAT_LEN-1, the next valid bit completes a full window
// ARMED returns to FILLING on clr, reset, or a match when OVERLAP=0.

module seq_det_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                FILL_W  = $clog2(PAT_LEN+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic              inp,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] pat_mask,
`endif
  output logic              outp,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              cnt_sat,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] ARM_LVL  = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(PAT_LEN);

  // Only the newest PAT_LEN-1 bits are ever needed: the oldest bit of a
  // PAT_LEN-wide history would fall out of the window on the next shift.
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cnt_sat;
  logic               r_outp;

  logic [PAT_LEN-1:0] w_window;
  logic [PAT_LEN-1:0] w_cmp_mask;
  logic               w_hit;
  logic               w_armed;
  logic               w_match;
  logic [FILL_W-1:0]  w_fill_inc;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cnt_max;

  assign w_window = {r_hist, inp};

`ifdef SEQ_DET_MASK_EN
  assign w_cmp_mask = pat_mask;
`else
  assign w_cmp_mask = '1;
`endif

  assign w_hit      = ((w_window ^ PATTERN) & w_cmp_mask) == '0;
  assign w_armed    = (r_fill >= ARM_LVL);
  assign w_match    = in_valid & w_armed & w_hit;
  assign w_fill_inc = (r_fill == FULL_LVL) ? r_fill : r_fill + 1'b1;
  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_cnt_max  = &r_cnt;

  // History, fill level, match pulse and statistics; clr outranks in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
      r_outp    <= 1'b0;
    end else if (clr) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
      r_outp    <= 1'b0;
    end else begin
      r_outp <= w_match;
      if (in_valid) begin
        if (w_match && (OVERLAP == 1'b0)) begin
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_hist <= w_window[PAT_LEN-2:0];
          r_fill <= w_fill_inc;
        end
      end
      if (w_match && !w_cnt_max) begin
        r_cnt <= w_cnt_nxt;
        if (&w_cnt_nxt) begin
          r_cnt_sat <= 1'b1;
        end
      end
    end
  end

  assign outp      = r_outp;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_cnt_sat;
  assign fill      = r_fill;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: three instances (overlapping, non-
// overlapping, 2-bit counter) share one stimulus stream. Each issued bit
// pushes the hand-computed expected counter value for every instance that
// must pulse; a negedge monitor pops on each outp pulse and compares.
// Build with SEQ_DET_MASK_EN defined to also exercise pat_mask.

module tb_seq_det_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, in_valid, inp;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] pat_mask;
`endif

  logic       o_ov, o_nov, o_sd;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sd;
  logic       sat_ov, sat_nov, sat_sd;
  logic [2:0] fill_ov, fill_nov, fill_sd;

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
`ifdef SEQ_DET_MASK_EN
    .pat_mask(pat_mask),
`endif
    .outp(o_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov), .fill(fill_ov));

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
`ifdef SEQ_DET_MASK_EN
    .pat_mask(pat_mask),
`endif
    .outp(o_nov), .match_cnt(cnt_nov), .cnt_sat(sat_nov), .fill(fill_nov));

  seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sd (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inp(inp),
`ifdef SEQ_DET_MASK_EN
    .pat_mask(pat_mask),
`endif
    .outp(o_sd), .match_cnt(cnt_sd), .cnt_sat(sat_sd), .fill(fill_sd));

  int   n_cmp = 0;
  int   n_err = 0;
  bit   done  = 1'b0;
  int   q_cnt [3][$];
  int   q_sat [3][$];
  logic act_out [3];
  logic act_sat [3];
  int   act_cnt [3];
  int   act_fill[3];
  string nm[3] = '{"ov", "nov", "sat"};

  assign act_out[0] = o_ov;   assign act_out[1] = o_nov;   assign act_out[2] = o_sd;
  assign act_sat[0] = sat_ov; assign act_sat[1] = sat_nov; assign act_sat[2] = sat_sd;
  assign act_cnt[0] = int'(cnt_ov);   assign act_cnt[1] = int'(cnt_nov);   assign act_cnt[2] = int'(cnt_sd);
  assign act_fill[0] = int'(fill_ov); assign act_fill[1] = int'(fill_nov); assign act_fill[2] = int'(fill_sd);

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every outp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && !done) begin
      for (int k = 0; k < 3; k++) begin
        if (act_out[k]) begin
          if (q_cnt[k].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_unexpected_pulse: got pulse (cnt %0d) expected none", nm[k], act_cnt[k]);
          end else begin
            int ec, es;
            ec = q_cnt[k].pop_front();
            es = q_sat[k].pop_front();
            check({nm[k], "_pulse_cnt"}, act_cnt[k], ec);
            check({nm[k], "_pulse_sat"}, int'(act_sat[k]), es);
          end
        end
      end
    end
  end

  // e0/e1/e2: expected match_cnt at the pulse for ov/nov/sat, -1 = no pulse.
  task automatic send(input logic b, input int e0, input int e1, input int e2, input int s2);
    in_valid = 1'b1;
    inp      = b;
    if (e0 >= 0) begin q_cnt[0].push_back(e0); q_sat[0].push_back(0);  end
    if (e1 >= 0) begin q_cnt[1].push_back(e1); q_sat[1].push_back(0);  end
    if (e2 >= 0) begin q_cnt[2].push_back(e2); q_sat[2].push_back(s2); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_quiet(input logic b);
    send(b, -1, -1, -1, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // clr presented together with a valid 1 that must be discarded.
  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b1; inp = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; inp = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_", nm[k], "_missing_pulses"}, q_cnt[k].size(), 0);
      q_cnt[k].delete();
      q_sat[k].delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_", nm[k], "_fill"}, act_fill[k], 0);
      check({tag, "_", nm[k], "_cnt"},  act_cnt[k], 0);
      check({tag, "_", nm[k], "_sat"},  int'(act_sat[k]), 0);
    end
  endtask

  int          e0_t[16] = '{-1,-1,-1,1,-1,-1,2,-1,-1,3,-1,-1,4,-1,-1,5};
  int          e1_t[16] = '{-1,-1,-1,1,-1,-1,-1,-1,-1,2,-1,-1,-1,-1,-1,3};
  int          e2_t[16] = '{-1,-1,-1,1,-1,-1,2,-1,-1,3,-1,-1,3,-1,-1,3};
  int          s2_t[16] = '{0,0,0,0,0,0,0,0,0,1,0,0,1,0,0,1};
  logic [15:0] stream;

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; inp = 1'b0;
`ifdef SEQ_DET_MASK_EN
    pat_mask = 4'b1111;
`endif
    #1 rst = 1'b0;
    #10;
    for (int k = 0; k < 3; k++) begin
      check({"reset_", nm[k], "_outp"}, int'(act_out[k]), 0);
    end
    check_cleared("reset");
    @(posedge clk); #1 rst = 1'b1;

    // Stream 1011011: overlap pulses after bits 4 and 7; non-overlap only after 4.
    send_quiet(1); send_quiet(0); send_quiet(1);
    send(1, 1, 1, 1, 0);
    send_quiet(0); send_quiet(1);
    send(1, 2, -1, 2, 0);
    idle(1);
    check_empty("t1");
    check("t1_ov_cnt",   act_cnt[0], 2);
    check("t1_ov_fill",  act_fill[0], 4);
    check("t1_nov_cnt",  act_cnt[1], 1);
    check("t1_nov_fill", act_fill[1], 3);
    check("t1_sat_cnt",  act_cnt[2], 2);
    do_clr();
    check_cleared("clr1");

    // Valid gap inside the pattern: no pulse during the gap, one at the end.
    send_quiet(1); send_quiet(0); send_quiet(1);
    idle(5);
    send(1, 1, 1, 1, 0);
    idle(1);
    check_empty("t2");
    check("t2_ov_cnt",   act_cnt[0], 1);
    check("t2_ov_fill",  act_fill[0], 4);
    check("t2_nov_fill", act_fill[1], 0);
    do_clr();

    // Asynchronous reset mid-pattern: the straddling pattern is never detected.
    send_quiet(1); send_quiet(0); send_quiet(1);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    send_quiet(1);
    idle(1);
    check_empty("t3");
    for (int k = 0; k < 3; k++) begin
      check({"t3_", nm[k], "_fill"}, act_fill[k], 1);
      check({"t3_", nm[k], "_cnt"},  act_cnt[k], 0);
    end
    do_clr();

    // Same with clr; the bit presented alongside clr is dropped.
    send_quiet(1); send_quiet(0); send_quiet(1);
    do_clr();
    send_quiet(1);
    idle(1);
    check_empty("t3b");
    for (int k = 0; k < 3; k++) begin
      check({"t3b_", nm[k], "_fill"}, act_fill[k], 1);
      check({"t3b_", nm[k], "_cnt"},  act_cnt[k], 0);
    end
    do_clr();

    // Five overlapping matches: 2-bit counter goes 1,2,3,3,3 and saturates.
    stream = 16'b1011011011011011;
    for (int i = 0; i < 16; i++) begin
      send(stream[15-i], e0_t[i], e1_t[i], e2_t[i], s2_t[i]);
    end
    idle(1);
    check_empty("t4");
    check("t4_ov_cnt",   act_cnt[0], 5);
    check("t4_ov_fill",  act_fill[0], 4);
    check("t4_nov_cnt",  act_cnt[1], 3);
    check("t4_nov_fill", act_fill[1], 0);
    check("t4_sat_cnt",  act_cnt[2], 3);
    check("t4_sat_flag", int'(act_sat[2]), 1);
    do_clr();
    check_cleared("clr4");

`ifdef SEQ_DET_MASK_EN
    // Masked compare: 1001 matches 1011 when bit 1 is don't care.
    pat_mask = 4'b1101;
    send_quiet(1); send_quiet(0); send_quiet(0);
    send(1, 1, 1, 1, 0);
    idle(1);
    check_empty("m1");
    check("m1_ov_cnt", act_cnt[0], 1);
    do_clr();

    pat_mask = 4'b1111;
    send_quiet(1); send_quiet(0); send_quiet(0); send_quiet(1);
    idle(1);
    check_empty("m2");
    check("m2_ov_cnt", act_cnt[0], 0);
    do_clr();

    // All-zero mask: every valid bit matches once armed.
    pat_mask = 4'b0000;
    send_quiet(0); send_quiet(0); send_quiet(0);
    send(0, 1, 1, 1, 0);
    send(0, 2, -1, 2, 0);
    idle(1);
    check_empty("m3");
    check("m3_nov_fill", act_fill[1], 1);
    pat_mask = 4'b1111;
    do_clr();
`endif

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_param.md
Name: seq_det_param

Overview:
- Parametrised serial sequence detector; successor to the fixed-pattern single-bit FSM detector.
- Watches a 1-bit stream, qualified by a valid strobe, for a PAT_LEN-bit pattern set at elaboration time.
- Overlapping or non-overlapping detection, chosen by parameter; saturating match counter; synchronous clear.
- Sits between a serial front end (deserialiser/UART bit stream) and control logic that needs match pulses and statistics.

Parameters:
- PAT_LEN, 4, pattern length in bits, legal range 2..32.
- PATTERN, 4'b1011, target pattern [PAT_LEN-1:0]; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping detection (history kept after a match); 0 = non-overlapping (history discarded after a match).
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- clr  input  1  synchronous clear of history, fill count, match_cnt and cnt_sat
- in_valid  input  1  inp is sampled only when high
- inp  input  1  serial data bit
- outp  output  1  registered one-cycle match pulse
- match_cnt  output  CNT_W  number of matches, saturating
- cnt_sat  output  1  sticky; high once match_cnt has reached all-ones
- fill  output  $clog2(PAT_LEN+1)  number of valid bits in history, saturating at PAT_LEN

Behaviour:
- Reset (rst=0, asynchronous): hist=0, fill=0, outp=0, match_cnt=0, cnt_sat=0. Release is synchronous to clk.
- History: shift register hist[PAT_LEN-1:0]. On an edge with in_valid=1: hist <= {hist[PAT_LEN-2:0], inp}; fill <= min(fill+1, PAT_LEN).
- in_valid=0: hist, fill and match_cnt hold; outp <= 0.
- Match condition, evaluated on an edge with in_valid=1: fill >= PAT_LEN-1 AND {hist[PAT_LEN-2:0], inp} == PATTERN (masked compare when the optional feature is enabled).
- Before PAT_LEN valid bits have been taken since reset, clr or a non-overlap match, no match can be declared. Stale zero history never matches.
- Match response, registered on the same edge:
  - outp <= 1 for exactly one cycle, visible in the cycle after the final pattern bit was presented. Latency is 1 clk from sample to pulse.
  - match_cnt <= match_cnt+1 unless it is already all-ones; it then holds and cnt_sat stays 1.
  - OVERLAP=1: hist shifts normally and fill stays at PAT_LEN, so the next match can come one bit later when the pattern self-overlaps.
  - OVERLAP=0: fill <= 0 and hist <= 0. The next match needs PAT_LEN new bits.
- Otherwise outp <= 0. Back-to-back valid matches give consecutive outp=1 cycles, one per match.
- clr=1 has priority over in_valid:
  - hist=0, fill=0, match_cnt=0, cnt_sat=0, outp<=0.
  - The bit presented in that cycle is discarded.
- Asynchronous reset mid-stream discards partial history. A pattern that straddles reset is never detected.
- State view for documentation: FILLING (fill < PAT_LEN-1) -> ARMED (fill >= PAT_LEN-1). ARMED -> FILLING on clr, reset, or a match when OVERLAP=0.

Optional Feature:
- Macro SEQ_DET_MASK_EN.
- Defined: adds input pat_mask [PAT_LEN-1:0]. A bit set to 1 means the position is compared; 0 means don't care. The compare becomes ((window ^ PATTERN) & pat_mask) == 0. pat_mask is sampled live each cycle.
- pat_mask all-zero with fill >= PAT_LEN-1 matches on every valid bit.
- Not defined: no pat_mask port; exact compare on all bits.

Test Plan:
- PATTERN=1011, OVERLAP=1, rst released, in_valid=1, stream 1,0,1,1,0,1,1 -> outp pulses after bits 4 and 7; match_cnt=2; fill=4.
- Same stream with OVERLAP=0 -> single pulse after bit 4; no pulse after bit 7 (only 3 new bits); match_cnt=1.
- OVERLAP=1, stream 1,0,1 then in_valid=0 for 5 cycles, then 1 with in_valid=1 -> outp=0 throughout the gap; one pulse after the final 1; match_cnt=1.
- Stream 1,0,1, assert rst=0 for 1 cycle, release, then stream 1 -> no pulse; fill=1. Same test with clr=1 in place of rst gives the same result.
- CNT_W=2, five valid matches -> match_cnt sequence 1,2,3,3,3; cnt_sat=1 from the third match; outp still pulses 5 times.
- SEQ_DET_MASK_EN defined, pat_mask=1101, stream 1,0,0,1 -> match pulse and match_cnt=1. With pat_mask=1111 the same stream gives no pulse.
